// File: rtl/exc_seq.sv
// exc_seq: exception/interrupt entry and return sequencer for the multi-cycle
// MIPS core. Arbitrates synchronous exceptions, ERET and NUM_IRQ external
// interrupt lines, then walks the CP0 write sequence (EPC, Cause, Status) and
// the handler jump while holding the core FSM.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   irq, irq_mask         external lines (index 0 = highest priority), enables
//   at_fetch              core is at the IF boundary (only IRQ entry point)
//   sys_req/ri_req/ov_req synchronous exception pulses from the main controller
//   eret_req              ERET decoded pulse
//   core_hold             freeze core FSM and PC
//   cp0_write, cp0_dst    CP0 write strobe / target (0 EPC, 1 Cause, 2 Status)
//   epc_src               0 = current PC, 1 = PC-4
//   cause_code, irq_id    ExcCode and serviced line, latched at arbitration
//   pc_write, pc_sel      PC load strobe / source (0 vector, 1 EPC)
//   irq_ack               one-hot acknowledge, asserted in W_EPC
//   in_handler            handler active flag
//   state_out             FSM state for debug
//
// Build option: define IRQ_EDGE_EN for edge-triggered pending latches;
// otherwise the pending register follows the irq lines (level mode).
//
// state     | meaning
// IDLE      | arbitrate requests; core runs unless a request is accepted
// W_EPC     | write EPC, acknowledge serviced IRQ line
// W_CAUSE   | write Cause (cause_code, irq_id valid)
// W_STATUS  | write Status (CP0 pushes the IE stack)
// J_HANDLER | load handler vector into PC, enter handler
// RET       | ERET: load EPC into PC, restore Status, leave handler

module exc_seq #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic                at_fetch,
    input  logic                sys_req,
    input  logic                ri_req,
    input  logic                ov_req,
    input  logic                eret_req,
    output logic                core_hold,
    output logic                cp0_write,
    output logic [1:0]          cp0_dst,
    output logic                epc_src,
    output logic [4:0]          cause_code,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic                pc_write,
    output logic                pc_sel,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                in_handler,
    output logic [2:0]          state_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_EPC     = 3'd1,
        W_CAUSE   = 3'd2,
        W_STATUS  = 3'd3,
        J_HANDLER = 3'd4,
        RET       = 3'd5
    } state_t;

    state_t                state, next_state;
    logic [NUM_IRQ-1:0]    pend;
    logic [4:0]            cause_q;
    logic [IRQ_ID_W-1:0]   id_q;
    logic                  sync_q;

    logic                  irq_hit;
    logic [IRQ_ID_W-1:0]   irq_sel;
    logic                  take;
    logic                  take_sync;
    logic [4:0]            code_nxt;
    logic [IRQ_ID_W-1:0]   id_nxt;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q;

    // A set in the same cycle as the ack must survive, so set is ORed last.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
            pend  <= '0;
        end else begin
            irq_q <= irq;
            pend  <= (pend & ~irq_ack) | (irq & ~irq_q);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= irq;
    end
`endif

    // Lowest enabled pending index wins: scan downward so the last hit sticks.
    always_comb begin
        irq_hit = 1'b0;
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i] && irq_mask[i]) begin
                irq_hit = 1'b1;
                irq_sel = IRQ_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_handler <= 1'b0;
            cause_q    <= 5'd0;
            id_q       <= '0;
            sync_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (take) begin
                cause_q <= code_nxt;
                id_q    <= id_nxt;
                sync_q  <= take_sync;
            end
            if (state == J_HANDLER)
                in_handler <= 1'b1;
            else if (state == RET)
                in_handler <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        core_hold  = (state != IDLE);
        take       = 1'b0;
        take_sync  = 1'b0;
        code_nxt   = 5'd0;
        id_nxt     = '0;
        cp0_write  = 1'b0;
        cp0_dst    = 2'd0;
        epc_src    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        irq_ack    = '0;

        case (state)
            IDLE: begin
                if (ri_req || sys_req || ov_req) begin
                    take      = 1'b1;
                    take_sync = 1'b1;
                    code_nxt  = ri_req ? 5'd10 : (sys_req ? 5'd8 : 5'd12);
                end else if (eret_req && in_handler) begin
                    next_state = RET;
                    core_hold  = 1'b1;
                end else if (irq_hit && at_fetch && !in_handler) begin
                    take   = 1'b1;
                    id_nxt = irq_sel;
                end
                if (take) begin
                    next_state = W_EPC;
                    core_hold  = 1'b1;
                end
            end
            W_EPC: begin
                cp0_write  = 1'b1;
                cp0_dst    = 2'd0;
                epc_src    = sync_q;
                for (int i = 0; i < NUM_IRQ; i++)
                    irq_ack[i] = !sync_q && (id_q == IRQ_ID_W'(i));
                next_state = W_CAUSE;
            end
            W_CAUSE: begin
                cp0_write  = 1'b1;
                cp0_dst    = 2'd1;
                next_state = W_STATUS;
            end
            W_STATUS: begin
                cp0_write  = 1'b1;
                cp0_dst    = 2'd2;
                next_state = J_HANDLER;
            end
            J_HANDLER: begin
                pc_write   = 1'b1;
                pc_sel     = 1'b0;
                next_state = IDLE;
            end
            RET: begin
                pc_write   = 1'b1;
                pc_sel     = 1'b1;
                cp0_write  = 1'b1;
                cp0_dst    = 2'd2;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign cause_code = cause_q;
    assign irq_id     = id_q;
    assign state_out  = state;

endmodule
